// File: rtl/shift_reg_serdes_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_serdes_ctrl_pkg
// Shared definitions for every block that drives the universal shift register:
// the register operation codes, the serdes controller state encoding and a
// helper that picks the shift direction from the bit-order parameter.
// -----------------------------------------------------------------------------
package shift_reg_serdes_ctrl_pkg;

    // Shift register operation codes on sr_select.
    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        HOLD  = 2'b10
    } state_e;

    // MSB-first frames leave through the MSB, so the register shifts left;
    // LSB-first frames leave through the LSB, so it shifts right.
    function automatic logic [1:0] shift_sel(input logic msb_first);
        if (msb_first) begin
            return SEL_LEFT;
        end else begin
            return SEL_RIGHT;
        end
    endfunction

endpackage

// File: rtl/shift_reg_serdes_ctrl_bit_rate_div.sv
// -----------------------------------------------------------------------------
// shift_reg_serdes_ctrl_bit_rate_div
// Bit-rate divider: counts 0..DIV-1 while enabled and emits a one-cycle tick
// in the last cycle of each bit period. Cleared at frame start so every frame
// begins with a full bit period.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   clr   in  restart the count (frame start)
//   en    in  count enable (controller is shifting)
//   tick  out high in the last cycle of a bit period while enabled
// -----------------------------------------------------------------------------
module shift_reg_serdes_ctrl_bit_rate_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(DIV + 1);

    logic [CW-1:0] cnt_r;

    assign tick = en && (cnt_r == CW'(DIV - 1));

    // Divider count: restarts on clear and after each tick, advances while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (tick) begin
            cnt_r <= {CW{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/shift_reg_serdes_ctrl.sv
// -----------------------------------------------------------------------------
// shift_reg_serdes_ctrl
// Sequences an external universal shift register as a framed, full-duplex
// serial port: parallel-load a TX word, shift it out while shifting ser_in in,
// then present the captured word on the RX handshake.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   tx_data/tx_valid/tx_ready  parallel TX handshake
//   rx_data/rx_valid/rx_ready  parallel RX handshake
//   ser_in, ser_out            serial pins
//   ser_frame                  high during every cycle of a frame's bit periods
//   sr_select, sr_p_din,
//   sr_s_left_din,
//   sr_s_right_din             register control (00 hold, 01 right, 10 left, 11 load)
//   sr_p_dout, sr_s_left_dout,
//   sr_s_right_dout            register state (word, MSB, LSB)
// -----------------------------------------------------------------------------
module shift_reg_serdes_ctrl
    import shift_reg_serdes_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_frame,
    output logic [1:0]       sr_select,
    output logic [WIDTH-1:0] sr_p_din,
    output logic             sr_s_left_din,
    output logic             sr_s_right_din,
    input  logic [WIDTH-1:0] sr_p_dout,
    input  logic             sr_s_left_dout,
    input  logic             sr_s_right_dout
);

    localparam int BCW = $clog2(WIDTH + 1);

    state_e         state_r;
    state_e         state_nxt_s;
    logic [BCW-1:0] bit_cnt_r;
    logic           tick_s;
    logic           load_s;
    logic           last_bit_s;
    logic           shifting_s;

    assign shifting_s = (state_r == SHIFT);
    assign last_bit_s = (bit_cnt_r == BCW'(WIDTH - 1));

    shift_reg_serdes_ctrl_bit_rate_div #(
        .DIV (DIV)
    ) u_bit_rate_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load_s),
        .en    (shifting_s),
        .tick  (tick_s)
    );

    // The load word is always presented; it only matters when sr_select is LOAD.
    assign sr_p_din       = tx_data;
    assign sr_s_left_din  = ser_in;
    assign sr_s_right_din = ser_in;

    // Status outputs are plain decodes of the state register.
    assign ser_frame = shifting_s;
    assign rx_valid  = (state_r == HOLD);
    assign rx_data   = (state_r == HOLD) ? sr_p_dout : {WIDTH{1'b0}};
    assign ser_out   = shifting_s ? ((MSB_FIRST != 0) ? sr_s_left_dout : sr_s_right_dout)
                                  : 1'b0;

    // Next state, handshake readiness and register op for the current cycle.
    always_comb begin
        state_nxt_s = state_r;
        sr_select   = SEL_HOLD;
        tx_ready    = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    load_s      = 1'b1;
                    sr_select   = SEL_LOAD;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (tick_s) begin
                    sr_select = shift_sel(MSB_FIRST != 0);
                    if (last_bit_s) begin
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            HOLD: begin
                // A new word may only enter when the captured one leaves on the
                // same edge, which makes back-to-back frames gap-free.
                tx_ready = rx_ready;
                if (rx_ready && tx_valid) begin
                    load_s      = 1'b1;
                    sr_select   = SEL_LOAD;
                    state_nxt_s = SHIFT;
                end else if (rx_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bit counter: cleared on frame start and after the last shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= {BCW{1'b0}};
        end else if (load_s) begin
            bit_cnt_r <= {BCW{1'b0}};
        end else if (shifting_s && tick_s) begin
            if (last_bit_s) begin
                bit_cnt_r <= {BCW{1'b0}};
            end else begin
                bit_cnt_r <= bit_cnt_r + BCW'(1);
            end
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

endmodule

// File: tb/tb_shift_reg_serdes_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_serdes_ctrl
// Three controller instances, each paired with a behavioural universal shift
// register: cfg0 WIDTH=4/DIV=1/MSB first, cfg1 WIDTH=4/DIV=1/LSB first,
// cfg2 WIDTH=4/DIV=3/MSB first. Expected serial bits and RX words are queued
// when a frame is offered and popped as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_shift_reg_serdes_ctrl;

    logic       clk;
    logic       rst_n;

    logic [3:0] tx_data_a  [3];
    logic       tx_valid_a [3];
    logic       rx_ready_a [3];
    logic       loop_a     [3];
    logic       fixed_a    [3];

    logic       tx_ready_a  [3];
    logic       rx_valid_a  [3];
    logic       ser_out_a   [3];
    logic       ser_frame_a [3];
    logic [3:0] rx_data_a   [3];
    logic [1:0] sr_sel_a    [3];

    int         checks;
    int         errors;

    logic       bit_q [$];
    logic [3:0] rx_q  [$];

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int DIV_G = (g == 2) ? 3 : 1;
        localparam int MSB_G = (g == 1) ? 0 : 1;

        logic       ser_in_s;
        logic [1:0] sel_s;
        logic [3:0] p_din_s;
        logic       sl_din_s;
        logic       sr_din_s;
        logic [3:0] q_r;

        assign ser_in_s    = loop_a[g] ? ser_out_a[g] : fixed_a[g];
        assign sr_sel_a[g] = sel_s;

        shift_reg_serdes_ctrl #(
            .WIDTH     (4),
            .DIV       (DIV_G),
            .MSB_FIRST (MSB_G)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .tx_data         (tx_data_a[g]),
            .tx_valid        (tx_valid_a[g]),
            .tx_ready        (tx_ready_a[g]),
            .rx_data         (rx_data_a[g]),
            .rx_valid        (rx_valid_a[g]),
            .rx_ready        (rx_ready_a[g]),
            .ser_in          (ser_in_s),
            .ser_out         (ser_out_a[g]),
            .ser_frame       (ser_frame_a[g]),
            .sr_select       (sel_s),
            .sr_p_din        (p_din_s),
            .sr_s_left_din   (sl_din_s),
            .sr_s_right_din  (sr_din_s),
            .sr_p_dout       (q_r),
            .sr_s_left_dout  (q_r[3]),
            .sr_s_right_dout (q_r[0])
        );

        // Behavioural universal shift register driven by the controller.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_r <= 4'b0000;
            end else begin
                case (sel_s)
                    2'b11:   q_r <= p_din_s;
                    2'b10:   q_r <= {q_r[2:0], sl_din_s};
                    2'b01:   q_r <= {sr_din_s, q_r[3:1]};
                    default: q_r <= q_r;
                endcase
            end
        end
    end

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit in case a wait escapes its bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Queue the serial bits and the RX word a frame is expected to produce.
    task automatic push_exp(input logic [3:0] data, input int c, input logic loop, input logic fixed);
        int  div;
        logic b;
        div = (c == 2) ? 3 : 1;
        for (int i = 0; i < 4; i++) begin
            b = (c != 1) ? data[3 - i] : data[i];
            for (int j = 0; j < div; j++) begin
                bit_q.push_back(b);
            end
        end
        rx_q.push_back(loop ? data : {4{fixed}});
    endtask

    // Called right after the accept edge; follows the frame until rx_valid.
    task automatic collect(input int c, input string tag);
        int         div;
        int         frame_n;
        int         first_k;
        logic       done;
        logic       exp_b;
        logic [3:0] exp_w;
        div     = (c == 2) ? 3 : 1;
        frame_n = 0;
        first_k = 0;
        done    = 1'b0;
        for (int k = 1; (k <= 4 * div + 8) && !done; k++) begin
            @(negedge clk);
            tx_valid_a[c] = 1'b0;
            #1;
            if (ser_frame_a[c]) begin
                frame_n++;
                if (first_k == 0) first_k = k;
                if (bit_q.size() == 0) begin
                    check_val({tag, " bit_q underflow"}, 32'(bit_q.size()), 32'd1);
                end else begin
                    exp_b = bit_q.pop_front();
                    check_val($sformatf("%s ser_out k=%0d", tag, k), 32'(ser_out_a[c]), 32'(exp_b));
                end
            end else begin
                check_val($sformatf("%s ser_out idle k=%0d", tag, k), 32'(ser_out_a[c]), 32'd0);
            end
            if (rx_valid_a[c]) begin
                done = 1'b1;
                check_val({tag, " rx latency"}, 32'(k), 32'(4 * div + 1));
                check_val({tag, " frame length"}, 32'(frame_n), 32'(4 * div));
                check_val({tag, " frame start"}, 32'(first_k), 32'd1);
                if (rx_q.size() == 0) begin
                    check_val({tag, " rx_q underflow"}, 32'(rx_q.size()), 32'd1);
                end else begin
                    exp_w = rx_q.pop_front();
                    check_val({tag, " rx_data"}, 32'(rx_data_a[c]), 32'(exp_w));
                end
            end
        end
        check_val({tag, " rx_valid seen"}, 32'(done), 32'd1);
        check_val({tag, " bit_q drained"}, 32'(bit_q.size()), 32'd0);
    endtask

    task automatic run_frame(input int c, input logic [3:0] data, input logic loop,
                             input logic fixed, input string tag);
        @(negedge clk);
        loop_a[c]     = loop;
        fixed_a[c]    = fixed;
        tx_data_a[c]  = data;
        tx_valid_a[c] = 1'b1;
        rx_ready_a[c] = 1'b1;
        #1;
        check_val({tag, " tx_ready"}, 32'(tx_ready_a[c]), 32'd1);
        push_exp(data, c, loop, fixed);
        collect(c, tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_data_a[i]  = 4'b0000;
            tx_valid_a[i] = 1'b0;
            rx_ready_a[i] = 1'b0;
            loop_a[i]     = 1'b1;
            fixed_a[i]    = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("reset tx_ready c%0d", i), 32'(tx_ready_a[i]), 32'd1);
            check_val($sformatf("reset rx_valid c%0d", i), 32'(rx_valid_a[i]), 32'd0);
            check_val($sformatf("reset ser_frame c%0d", i), 32'(ser_frame_a[i]), 32'd0);
            check_val($sformatf("reset ser_out c%0d", i), 32'(ser_out_a[i]), 32'd0);
            check_val($sformatf("reset sr_select c%0d", i), 32'(sr_sel_a[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(0, 4'b1101, 1'b1, 1'b0, "loop msb");
        run_frame(1, 4'b1101, 1'b1, 1'b0, "loop lsb");
        run_frame(0, 4'b1010, 1'b0, 1'b0, "ser_in0");
        run_frame(2, 4'b1001, 1'b1, 1'b0, "div3");

        // Backpressure, then same-edge unload and reload.
        @(negedge clk);
        loop_a[0]     = 1'b1;
        tx_data_a[0]  = 4'b1101;
        tx_valid_a[0] = 1'b1;
        rx_ready_a[0] = 1'b0;
        #1;
        check_val("bp tx_ready", 32'(tx_ready_a[0]), 32'd1);
        push_exp(4'b1101, 0, 1'b1, 1'b0);
        collect(0, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tx_valid_a[0] = 1'b1;
            tx_data_a[0]  = 4'b0110;
            #1;
            check_val($sformatf("bp rx_valid %0d", i), 32'(rx_valid_a[0]), 32'd1);
            check_val($sformatf("bp rx_data %0d", i), 32'(rx_data_a[0]), 32'hd);
            check_val($sformatf("bp tx_ready %0d", i), 32'(tx_ready_a[0]), 32'd0);
            check_val($sformatf("bp ser_frame %0d", i), 32'(ser_frame_a[0]), 32'd0);
        end
        @(negedge clk);
        rx_ready_a[0] = 1'b1;
        #1;
        check_val("b2b tx_ready", 32'(tx_ready_a[0]), 32'd1);
        check_val("b2b rx_data", 32'(rx_data_a[0]), 32'hd);
        check_val("b2b sr_select", 32'(sr_sel_a[0]), 32'd3);
        push_exp(4'b0110, 0, 1'b1, 1'b0);
        collect(0, "b2b");

        // Reset in the middle of a frame.
        @(negedge clk);
        tx_data_a[0]  = 4'b1101;
        tx_valid_a[0] = 1'b1;
        rx_ready_a[0] = 1'b1;
        @(negedge clk);
        tx_valid_a[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("mid ser_frame before", 32'(ser_frame_a[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid ser_frame", 32'(ser_frame_a[0]), 32'd0);
        check_val("mid ser_out", 32'(ser_out_a[0]), 32'd0);
        check_val("mid rx_valid", 32'(rx_valid_a[0]), 32'd0);
        check_val("mid tx_ready", 32'(tx_ready_a[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check_val($sformatf("post rst rx_valid %0d", i), 32'(rx_valid_a[0]), 32'd0);
            check_val($sformatf("post rst tx_ready %0d", i), 32'(tx_ready_a[0]), 32'd1);
        end

        run_frame(1, 4'b0011, 1'b0, 1'b1, "ser_in1 lsb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
